// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Optional write-to-read forwarding: define REGFILE_SB_BYPASS_EN.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears data and scoreboard)
//   rd_addr   NREAD packed read addresses, port i at [i*AW +: AW]
//   rd_data   NREAD packed combinational read data
//   rd_busy   NREAD hazard flags, read register has a pending write
//   wr_en     NWRITE per-port write enables
//   wr_addr   NWRITE packed write addresses
//   wr_data   NWRITE packed write data
//   iss_en    issue strobe, marks iss_addr pending
//   iss_addr  destination register of the issued instruction
//   busy_vec  registered scoreboard, bit r = register r pending
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Writes clear the pending bit, then an issue re-sets it,
  // so an issue in the same cycle as a write wins.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NWRITE; p++) begin
      if (wr_en[p]) begin
        busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Ascending port loop: the last NBA to a register wins,
  // giving the highest-indexed port priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      d = (a == '0) ? '0 : regs[a];
      b = busy[a] & ~rst;
`ifdef REGFILE_SB_BYPASS_EN
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_en[p] && (a != '0) &&
            (wr_addr[p*AW +: AW] == a)) begin
          d = wr_data[p*XLEN +: XLEN];
          b = 1'b0;
        end
      end
`endif
    end

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_busy[i]              = b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with a behavioural model.
// Honours REGFILE_SB_BYPASS_EN the same way as the design.
module tb_regfile_sb;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic [NREGS-1:0]       busy_vec;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0]  mreg [NREGS];
  logic [NREGS-1:0] mbusy;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS),
    .NREAD(NREAD), .NWRITE(NWRITE)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

  task automatic idle();
    rst = 1'b0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_en = 1'b0;
    iss_addr = '0;
    rd_addr = '0;
  endtask

  task automatic wr(input int p, input int a,
                    input logic [XLEN-1:0] v);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = v;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Model: reset clears all; each enabled write stores its data
  // (later ports overwrite earlier) and clears pending; an issue
  // then marks its destination pending. r0 stays 0 and idle.
  task automatic tick();
    int a;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mreg[r] = '0;
      mbusy = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_en[p]) begin
          a = int'(wr_addr[p*AW +: AW]);
          if (a != 0) mreg[a] = wr_data[p*XLEN +: XLEN];
          mbusy[a] = 1'b0;
        end
      end
      if (iss_en && iss_addr != '0) mbusy[iss_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic fwd_hit(input int a);
    if (a == 0) return 1'b0;
    for (int p = 0; p < NWRITE; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    for (int p = NWRITE - 1; p >= 0; p--)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a)
        return wr_data[p*XLEN +: XLEN];
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (rst) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (fwd_hit(a)) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    tests++;
    if (rd_busy !== '0) begin
      fails++;
      $display("FAIL reset_rd_busy got %b want 0", rd_busy);
    end
    tick();
    idle();
    for (int a = 0; a < NREGS; a++) begin
      rd(0, a);
      #1;
      tests++;
      if (rd_data[XLEN-1:0] !== '0) begin
        fails++;
        $display("FAIL reset_data r%0d got %h want 0",
                 a, rd_data[XLEN-1:0]);
      end
    end
    tests++;
    if (busy_vec !== '0) begin
      fails++;
      $display("FAIL reset_busy_vec got %h want 0", busy_vec);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    rd(0, 5);
    #1;
    tests++;
    if (rd_data[XLEN-1:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_r5 got %h want deadbeef",
               rd_data[XLEN-1:0]);
    end
    wr(1, 0, 32'h1234);
    rd(1, 0);
    #1;
    tests++;
    if (rd_data[2*XLEN-1:XLEN] !== '0) begin
      fails++;
      $display("FAIL r0_same_cycle got %h want 0",
               rd_data[2*XLEN-1:XLEN]);
    end
    tick();
    idle();
    rd(0, 0);
    #1;
    tests++;
    if (rd_data[XLEN-1:0] !== '0 || busy_vec[0] !== 1'b0) begin
      fails++;
      $display("FAIL r0_write got %h/%b want 0/0",
               rd_data[XLEN-1:0], busy_vec[0]);
    end
  endtask

  task automatic test_same_addr();
    idle();
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    tick();
    idle();
    rd(1, 7);
    #1;
    tests++;
    if (rd_data[2*XLEN-1:XLEN] !== 32'h22) begin
      fails++;
      $display("FAIL same_addr r7 got %h want 22",
               rd_data[2*XLEN-1:XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    rd(0, 3);
    #1;
    tests++;
    if (rd_busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL iss_busy got %b want 1", rd_busy[0]);
    end
    wr(0, 3, 32'h55);
    tick();
    idle();
    rd(0, 3);
    #1;
    tests++;
    if (rd_busy[0] !== 1'b0 || busy_vec[3] !== 1'b0 ||
        rd_data[XLEN-1:0] !== 32'h55) begin
      fails++;
      $display("FAIL wr_clears got %b/%b/%h want 0/0/55",
               rd_busy[0], busy_vec[3], rd_data[XLEN-1:0]);
    end
    iss_en = 1'b1;
    iss_addr = 5'd3;
    wr(1, 3, 32'h66);
    tick();
    idle();
    rd(0, 3);
    #1;
    tests++;
    if (busy_vec[3] !== 1'b1 ||
        rd_data[XLEN-1:0] !== 32'h66) begin
      fails++;
      $display("FAIL iss_wins got %b/%h want 1/66",
               busy_vec[3], rd_data[XLEN-1:0]);
    end
    iss_en = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    tests++;
    if (busy_vec[3] !== 1'b1) begin
      fails++;
      $display("FAIL reissue got %b want 1", busy_vec[3]);
    end
    iss_en = 1'b1;
    iss_addr = 5'd0;
    tick();
    idle();
    tests++;
    if (busy_vec[0] !== 1'b0) begin
      fails++;
      $display("FAIL iss_r0 got %b want 0", busy_vec[0]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] wd;
    logic            wb;
    idle();
    wr(0, 9, 32'hA0);
    iss_en = 1'b1;
    iss_addr = 5'd9;
    tick();
    idle();
    wr(0, 9, 32'hB0);
    rd(1, 9);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    wd = 32'hB0;
    wb = 1'b0;
`else
    wd = 32'hA0;
    wb = 1'b1;
`endif
    tests++;
    if (rd_data[2*XLEN-1:XLEN] !== wd || rd_busy[1] !== wb) begin
      fails++;
      $display("FAIL bypass r9 got %h/%b want %h/%b",
               rd_data[2*XLEN-1:XLEN], rd_busy[1], wd, wb);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    wr(0, 4, 32'h77);
    iss_en = 1'b1;
    iss_addr = 5'd4;
    tick();
    idle();
    rst = 1'b1;
    wr(1, 6, 32'h99);
    iss_en = 1'b1;
    iss_addr = 5'd8;
    rd(0, 4);
    #1;
    tests++;
    if (rd_busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_rd_busy got %b want 0", rd_busy[0]);
    end
    tick();
    idle();
    rd(0, 4);
    rd(1, 6);
    #1;
    tests++;
    if (rd_data !== '0 || busy_vec !== '0) begin
      fails++;
      $display("FAIL rst_prio got %h/%h want 0/0",
               rd_data, busy_vec);
    end
  endtask

  task automatic test_random();
    int a;
    for (int c = 0; c < 400; c++) begin
      idle();
      rst = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < NWRITE; p++) begin
        if ($urandom_range(0, 1) == 1)
          wr(p, $urandom_range(0, 7), $urandom);
      end
      iss_en = $urandom_range(0, 2) == 0;
      iss_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NREAD; i++)
        rd(i, $urandom_range(0, 7));
      #1;
      for (int i = 0; i < NREAD; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
        tests++;
        if (rd_data[i*XLEN +: XLEN] !== exp_data(a) ||
            rd_busy[i] !== exp_busy(a)) begin
          fails++;
          $display("FAIL rand c%0d p%0d r%0d got %h/%b want %h/%b",
                   c, i, a, rd_data[i*XLEN +: XLEN], rd_busy[i],
                   exp_data(a), exp_busy(a));
        end
      end
      tick();
      tests++;
      if (busy_vec !== mbusy) begin
        fails++;
        $display("FAIL rand_busy_vec c%0d got %h want %h",
                 c, busy_vec, mbusy);
      end
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_addr();
    test_scoreboard();
    test_bypass();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
